gray_serial_arb: RTL and testbench

Arbitrated, bit-serial binary<->Gray conversion engine for the code-conversion datapath.
- Two requesters share one 1-bit conversion slice.
- A round-robin arbiter grants one word at a time.
- An FSM walks the slice MSB-first over WIDTH cycles.
- The assembled result is presented on a valid/ready output port.
- Replaces per-requester parallel converters where area matters more than throughput.

---
 rtl/gray_pkg.sv | 15 +
 rtl/gray_bit_slice.sv | 16 +
 rtl/gray_serial_arb.sv | 135 +++++++++++++
 tb/tb_gray_serial_arb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the bit-serial binary/Gray conversion engine.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  localparam int GRAY_W = 4;

endpackage

// File: rtl/gray_bit_slice.sv
// One-bit conversion cell: combinational, zero latency, no flow control.
// The carried bit is the input bit for binary->Gray and the result bit for Gray->binary.
module gray_bit_slice
  import gray_pkg::*;
(
  input  logic in_bit,
  input  logic prev_bit,
  input  logic mode,
  output logic res_bit,
  output logic next_prev
);

  assign res_bit   = in_bit ^ prev_bit;
  assign next_prev = (mode == MODE_G2B) ? res_bit : in_bit;

endmodule

// File: rtl/gray_serial_arb.sv
// Two-requester round-robin front end feeding one serial Gray slice, MSB-first over WIDTH cycles.
// Result valid WIDTH+1 cycles after accept; held under out_ready backpressure, no accepts until drained.
module gray_serial_arb
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] out_data_q;
  logic [IW-1:0]    idx_q;
  logic             mode_q;
  logic             id_q;
  logic             last_grant_q;
  logic             prev_q;
  logic             out_valid_q;
  logic             out_id_q;

  logic             gnt_vld;
  logic             gnt_id;
  logic             slice_res;
  logic             slice_prev;

  // Ties go to the requester that was not served last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!rst && state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;

  gray_bit_slice u_slice (
    .in_bit    (in_q[idx_q]),
    .prev_bit  (prev_q),
    .mode      (mode_q),
    .res_bit   (slice_res),
    .next_prev (slice_prev)
  );

  always_comb begin
    res_d        = res_q;
    res_d[idx_q] = slice_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_q         <= '0;
      res_q        <= '0;
      out_data_q   <= '0;
      idx_q        <= IW'(WIDTH - 1);
      mode_q       <= MODE_B2G;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      prev_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            in_q         <= gnt_id ? req1_data : req0_data;
            mode_q       <= gnt_id ? req1_mode : req0_mode;
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
            prev_q       <= 1'b0;
            idx_q        <= IW'(WIDTH - 1);
            res_q        <= '0;
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res_q  <= res_d;
          prev_q <= slice_prev;
          if (idx_q == '0) begin
            out_data_q  <= res_d;
            out_id_q    <= id_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray_serial_arb.sv
// Bench for gray_serial_arb: directed scenarios, exhaustive round trips at WIDTH 4 and 8,
// and a randomized run against a transaction-level reference model.
module tb_gray_serial_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0v, r0r, r0m, r1v, r1r, r1m, ov, ordy, oid;
  logic [3:0] r0d, r1d, od;
  logic       e0v, e0r, e0m, e1v, e1r, e1m, eov, eordy, eoid;
  logic [7:0] e0d, e1d, eod;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_serial_arb #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r), .req0_data(r0d), .req0_mode(r0m),
    .req1_valid(r1v), .req1_ready(r1r), .req1_data(r1d), .req1_mode(r1m),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_id(oid)
  );

  gray_serial_arb #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(e0v), .req0_ready(e0r), .req0_data(e0d), .req0_mode(e0m),
    .req1_valid(e1v), .req1_ready(e1r), .req1_data(e1d), .req1_mode(e1m),
    .out_valid(eov), .out_ready(eordy), .out_data(eod), .out_id(eoid)
  );

  function automatic logic [7:0] ref_conv(input logic [7:0] v, input logic m);
    logic [7:0] b;
    if (!m) return v ^ (v >> 1);
    b = v;
    for (int s = 1; s < 8; s++) b = b ^ (v >> s);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r0v = 0; r1v = 0; e0v = 0; e1v = 0; ordy = 0; eordy = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic conv(input int w, input bit rq, input logic [7:0] d, input logic m,
                      output logic [7:0] r, output logic id, output bit to);
    int n;
    to = 0; r = '0; id = 0;
    if (w == 4) begin
      if (rq) begin r1v = 1; r1d = d[3:0]; r1m = m; end
      else    begin r0v = 1; r0d = d[3:0]; r0m = m; end
      ordy = 1;
    end else begin
      e0v = 1; e0d = d; e0m = m; eordy = 1;
    end
    #1;
    n = 0;
    while (!((w == 4) ? (rq ? r1r : r0r) : e0r) && n < 20) begin step(); #1; n++; end
    if (n >= 20) to = 1;
    step();
    r0v = 0; r1v = 0; e0v = 0;
    #1;
    n = 0;
    while (!((w == 4) ? ov : eov) && n < 40) begin step(); #1; n++; end
    if (n >= 40) to = 1;
    r  = (w == 4) ? {4'b0, od} : eod;
    id = (w == 4) ? oid : eoid;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r0v = 1; r0d = 4'h5; r0m = 0; r1v = 0; e0v = 0; e1v = 0; ordy = 1; eordy = 1;
    #1;
    checks++;
    if (r0r !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", r0r); end
    step();
    do_reset();
    #1;
    checks++;
    if ({ov, od, oid, r0r, r1r} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs got ov=%b od=%h id=%b r0=%b r1=%b want all 0", ov, od, oid, r0r, r1r);
    end
  endtask

  task automatic test_single_req0();
    int n, nacc;
    do_reset();
    r0v = 1; r0d = 4'h9; r0m = 0; ordy = 1;
    #1;
    checks++;
    if ({r0r, r1r} !== 2'b10) begin failures++; $display("FAIL t1_ready got=%b%b want=10", r0r, r1r); end
    nacc = cyc;
    step();
    r0v = 0;
    #1;
    n = 0;
    while (!ov && n < 20) begin step(); #1; n++; end
    checks++;
    if (cyc - nacc != 5) begin failures++; $display("FAIL t1_latency got=%0d want=5", cyc - nacc); end
    checks++;
    if (od !== 4'hD || oid !== 1'b0) begin
      failures++; $display("FAIL t1_result got=%h/%b want=d/0", od, oid);
    end
    step();
  endtask

  task automatic test_single_req1();
    logic [7:0] din[3]  = '{8'hD, 8'hA, 8'hF};
    logic       mdin[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] want[3] = '{8'h9, 8'hC, 8'h8};
    logic [7:0] r;
    logic id;
    bit to;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      conv(4, 1'b1, din[i], mdin[i], r, id, to);
      checks++;
      if (to || r !== want[i] || id !== 1'b1) begin
        failures++;
        $display("FAIL t2_req1_%0d got=%h/%b timeout=%0d want=%h/1", i, r, id, to, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nacc = 0, nout = 0, last_acc = 0;
    do_reset();
    r0v = 1; r0d = 4'h3; r0m = 0; r1v = 1; r1d = 4'h7; r1m = 0; ordy = 1;
    #1;
    for (int c = 0; c < 60 && nout < 4; c++) begin
      if (r0r || r1r) begin
        checks++;
        if (r1r !== 1'(nacc % 2) || (r0r && r1r)) begin
          failures++; $display("FAIL t3_grant_%0d got=%b%b want_id=%0d", nacc, r0r, r1r, nacc % 2);
        end
        if (nacc > 0) begin
          checks++;
          if (cyc - last_acc != 6) begin
            failures++; $display("FAIL t3_spacing got=%0d want=6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        nacc++;
      end
      if (ov) begin
        checks++;
        if (oid !== 1'(nout % 2) || od !== ((nout % 2) ? 4'h4 : 4'h2)) begin
          failures++;
          $display("FAIL t3_out_%0d got=%h/%b want=%h/%0d", nout, od, oid, (nout % 2) ? 4'h4 : 4'h2, nout % 2);
        end
        nout++;
      end
      step();
      #1;
    end
    checks++;
    if (nout < 4) begin failures++; $display("FAIL t3_count got=%0d want=4", nout); end
    r0v = 0; r1v = 0;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    r0v = 1; r0d = 4'h9; r0m = 0; ordy = 0;
    step();
    r0v = 0;
    #1;
    n = 0;
    while (!ov && n < 20) begin step(); #1; n++; end
    r1v = 1; r1d = 4'h5; r1m = 0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({ov, od, oid, r0r, r1r} !== {1'b1, 4'hD, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL t4_hold_%0d got ov=%b od=%h id=%b r=%b%b want 1/d/0/00", c, ov, od, oid, r0r, r1r);
      end
      step();
      #1;
    end
    ordy = 1;
    step();
    #1;
    checks++;
    if (ov !== 1'b0 || r1r !== 1'b1) begin
      failures++; $display("FAIL t4_release got ov=%b r1=%b want ov=0 r1=1", ov, r1r);
    end
    step();
    r1v = 0;
    #1;
    n = 0;
    while (!ov && n < 20) begin step(); #1; n++; end
    checks++;
    if (od !== 4'h7 || oid !== 1'b1) begin
      failures++; $display("FAIL t4_pending got=%h/%b want=7/1", od, oid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    r0v = 1; r0d = 4'h9; r0m = 0; ordy = 1;
    step();
    r0v = 0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({ov, od, oid} !== 6'b0) begin
        failures++; $display("FAIL t5_aborted_%0d got ov=%b od=%h id=%b want 0", c, ov, od, oid);
      end
      step();
      #1;
    end
    r0v = 1; r0d = 4'h1; r0m = 0; r1v = 1; r1d = 4'h6; r1m = 0;
    #1;
    checks++;
    if ({r0r, r1r} !== 2'b10) begin failures++; $display("FAIL t5_tie got=%b%b want=10", r0r, r1r); end
    step();
    r0v = 0; r1v = 0;
    #1;
    n = 0;
    while (!ov && n < 20) begin step(); #1; n++; end
    checks++;
    if (od !== 4'h1 || oid !== 1'b0) begin
      failures++; $display("FAIL t5_after got=%h/%b want=1/0", od, oid);
    end
    step();
  endtask

  task automatic test_roundtrip();
    logic [7:0] g, b;
    logic id;
    bit to1, to2;
    do_reset();
    for (int w = 4; w <= 8; w += 4) begin
      for (int v = 0; v < (1 << w); v++) begin
        conv(w, 1'b0, 8'(v), 1'b0, g, id, to1);
        conv(w, 1'b0, g, 1'b1, b, id, to2);
        checks++;
        if (to1 || g !== 8'(v ^ (v >> 1))) begin
          failures++; $display("FAIL t6_b2g_w%0d v=%h got=%h want=%h", w, v, g, 8'(v ^ (v >> 1)));
        end
        checks++;
        if (to2 || b !== 8'(v)) begin
          failures++; $display("FAIL t6_rt_w%0d v=%h got=%h", w, v, b);
        end
      end
    end
  endtask

  task automatic test_random();
    bit v0 = 0, v1 = 0, busy = 0, last = 1, gexp, exp_ov;
    logic [3:0] d0 = 0, d1 = 0, exp_d = 0;
    logic m0 = 0, m1 = 0, exp_id = 0;
    int acc_cyc = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1; d0 = 4'($urandom); m0 = 1'($urandom); end
      if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1; d1 = 4'($urandom); m1 = 1'($urandom); end
      r0v = v0; r0d = d0; r0m = m0; r1v = v1; r1d = d1; r1m = m1;
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      gexp = (v0 && v1) ? ~last : v1;
      checks++;
      if (!busy && (v0 || v1)) begin
        if ({r1r, r0r} !== (gexp ? 2'b10 : 2'b01)) begin
          failures++; $display("FAIL rnd_grant c=%0d got=%b%b want_id=%0d", c, r0r, r1r, gexp);
        end
      end else if ({r1r, r0r} !== 2'b00) begin
        failures++; $display("FAIL rnd_noready c=%0d got=%b%b want=00", c, r0r, r1r);
      end
      exp_ov = busy && (cyc - acc_cyc >= 5);
      checks++;
      if (ov !== exp_ov) begin
        failures++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, ov, exp_ov);
      end
      if (busy) begin
        if (exp_ov && ordy) begin
          checks++;
          if (od !== exp_d || oid !== exp_id) begin
            failures++; $display("FAIL rnd_data c=%0d got=%h/%b want=%h/%b", c, od, oid, exp_d, exp_id);
          end
          busy = 0;
        end
      end else if (v0 || v1) begin
        last    = gexp;
        exp_id  = gexp;
        exp_d   = 4'(ref_conv(gexp ? {4'b0, d1} : {4'b0, d0}, gexp ? m1 : m0));
        acc_cyc = cyc;
        busy    = 1;
        if (gexp) v1 = 0; else v0 = 0;
      end
      step();
    end
    r0v = 0; r1v = 0;
  endtask

  initial begin
    rst = 1'b1;
    r0v = 0; r0d = 0; r0m = 0; r1v = 0; r1d = 0; r1m = 0; ordy = 0;
    e0v = 0; e0d = 0; e0m = 0; e1v = 0; e1d = 0; e1m = 0; eordy = 0;
    step();
    test_reset();
    test_single_req0();
    test_single_req1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_roundtrip();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
